// File: rtl/cache_fill_fsm_pkg.sv
// ============================================================================
// Module      : cache_fill_fsm_pkg
// Description : Shared constants for the cache line fill sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_fill_fsm_pkg;

  localparam int c_DEF_ADDR_WIDTH      = 16;
  localparam int c_DEF_WORDS_PER_BLOCK = 8;

  // Byte offset within a block: word-index bits plus the byte-in-word bit.
  localparam int c_OFFSET_BITS = $clog2(c_DEF_WORDS_PER_BLOCK) + 1;
  localparam int c_WORD_IDX_W  = $clog2(c_DEF_WORDS_PER_BLOCK);

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_FILL = 1'b1;

  // Lowest address bit of the block (tag+set) field for a given block size.
  function automatic int offset_bits(input int words_per_block);
    return $clog2(words_per_block) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_fill_fsm_fill_counter.sv
// ============================================================================
// Module      : fill_counter
// Description : Up-counter with async reset, sync clear and count enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fill_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/cache_fill_fsm.sv
// ============================================================================
// Module      : cache_fill_fsm
// Description : Cache miss fill initiator; issues back-to-back word reads and
//               writes returned words, then the tag. Optional critical-word-
//               first ordering is enabled by CACHE_FILL_CRIT_WORD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int ADDR_WIDTH      = c_DEF_ADDR_WIDTH,
  parameter int WORDS_PER_BLOCK = c_DEF_WORDS_PER_BLOCK
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               miss_detected,
  input  logic [ADDR_WIDTH-1:0]              miss_address,
  input  logic                               memory_data_valid,
  output logic                               fsm_busy,
  output logic                               mem_enable,
  output logic                               mem_wr,
  output logic [ADDR_WIDTH-1:0]              memory_address,
  output logic                               write_data_array,
  output logic                               write_tag_array,
`ifdef CACHE_FILL_CRIT_WORD_EN
  output logic                               crit_word_ready,
`endif
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] word_index
);

  localparam int c_WIDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int c_OFF    = offset_bits(WORDS_PER_BLOCK);
  // One spare bit so issue_cnt can reach WORDS_PER_BLOCK without wrapping.
  localparam int c_CNT_W  = c_WIDX_W + 1;
  localparam int c_BLK_W  = ADDR_WIDTH - c_OFF;

  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(WORDS_PER_BLOCK);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WORDS_PER_BLOCK - 1);

  logic [0:0]          r_state;
  logic [c_BLK_W-1:0]  r_base;
  logic [c_CNT_W-1:0]  w_issue_cnt;
  logic [c_CNT_W-1:0]  w_ret_cnt;
  logic [c_WIDX_W-1:0] w_issue_word;
  logic [c_WIDX_W-1:0] w_ret_word;
  logic                w_fill;
  logic                w_start;
  logic                w_issuing;
  logic                w_ret;
  logic                w_last;
  logic                w_unused_addr_lsb;

  assign w_fill    = (r_state == c_ST_FILL);
  assign w_start   = (r_state == c_ST_IDLE) && miss_detected;
  assign w_issuing = w_fill && (w_issue_cnt < c_CNT_FULL);
  assign w_ret     = w_fill && memory_data_valid;
  assign w_last    = w_ret && (w_ret_cnt == c_CNT_LAST);

  assign w_unused_addr_lsb = ^miss_address[c_OFF-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      case (r_state)
        c_ST_IDLE: if (miss_detected) r_state <= c_ST_FILL;
        c_ST_FILL: if (w_last)        r_state <= c_ST_IDLE;
        default:                      r_state <= c_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base <= '0;
    end else if (w_start) begin
      r_base <= miss_address[ADDR_WIDTH-1:c_OFF];
    end
  end

  fill_counter #(.WIDTH(c_CNT_W)) u_issue_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_start),
    .i_en    (w_issuing),
    .o_count (w_issue_cnt)
  );

  fill_counter #(.WIDTH(c_CNT_W)) u_ret_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_start),
    .i_en    (w_ret),
    .o_count (w_ret_cnt)
  );

`ifdef CACHE_FILL_CRIT_WORD_EN
  logic [c_WIDX_W-1:0] r_start;
  logic                w_crit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start <= '0;
    end else if (w_start) begin
      r_start <= miss_address[c_OFF-1:1];
    end
  end

  // Word-index width truncation gives the wrap within the block.
  assign w_issue_word    = r_start + w_issue_cnt[c_WIDX_W-1:0];
  assign w_ret_word      = r_start + w_ret_cnt[c_WIDX_W-1:0];
  assign w_crit          = w_ret && (w_ret_cnt == '0);
  assign crit_word_ready = w_crit;
  assign fsm_busy        = w_fill && !w_crit;
`else
  assign w_issue_word = w_issue_cnt[c_WIDX_W-1:0];
  assign w_ret_word   = w_ret_cnt[c_WIDX_W-1:0];
  assign fsm_busy     = w_fill;
`endif

  assign mem_enable       = w_issuing;
  assign mem_wr           = 1'b0;
  assign memory_address   = w_issuing ? {r_base, w_issue_word, 1'b0} : '0;
  assign write_data_array = w_ret;
  assign write_tag_array  = w_last;
  assign word_index       = w_ret ? w_ret_word : '0;

endmodule

`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
// ============================================================================
// Module      : tb_cache_fill_fsm
// Description : Directed scoreboard bench for cache_fill_fsm with a fixed-
//               latency memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic        write_tag_array;
  logic [2:0]  word_index;
`ifdef CACHE_FILL_CRIT_WORD_EN
  logic        crit_word_ready;
`endif

  always #5 clk = ~clk;

  cache_fill_fsm #(.ADDR_WIDTH(16), .WORDS_PER_BLOCK(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_enable        (mem_enable),
    .mem_wr            (mem_wr),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
`ifdef CACHE_FILL_CRIT_WORD_EN
    .crit_word_ready   (crit_word_ready),
`endif
    .word_index        (word_index)
  );

  // Memory returns one word 'lat' cycles after each request; not reset by rst.
  logic [7:0] r_sr = '0;
  int         lat = 4;
  logic       force_valid = 1'b0;
  always @(posedge clk) r_sr <= {r_sr[6:0], mem_enable};
  assign memory_data_valid = r_sr[lat-1] | force_valid;

  logic [15:0] addr_q[$];
  logic [2:0]  idx_q[$];
  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc, first_req, last_req, first_wr, tag_cyc, fill_wr, n_tag = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [15:0] ea;
    logic [2:0]  ei;
    @(negedge clk);
    cyc++;
    if (mem_enable) begin
      if (addr_q.size() == 0) check("spurious_req", mem_enable, 0);
      else begin
        ea = addr_q.pop_front();
        check("req_addr", memory_address, ea);
        if (first_req < 0) first_req = cyc;
        last_req = cyc;
      end
    end
    if (write_data_array) begin
      fill_wr++;
      if (idx_q.size() == 0) check("spurious_wr", write_data_array, 0);
      else begin
        ei = idx_q.pop_front();
        check("word_index", word_index, ei);
        check("tag_with_last", write_tag_array, idx_q.size() == 0);
`ifdef CACHE_FILL_CRIT_WORD_EN
        check("crit_word_ready", crit_word_ready, fill_wr == 1);
        check("busy_in_fill", fsm_busy, fill_wr != 1);
`else
        check("busy_in_fill", fsm_busy, 1);
`endif
        if (first_wr < 0) first_wr = cyc;
      end
    end
`ifdef CACHE_FILL_CRIT_WORD_EN
    if (crit_word_ready && !write_data_array) check("crit_without_data", crit_word_ready, 0);
`endif
    if (write_tag_array) begin
      n_tag++;
      tag_cyc = cyc;
      if (!write_data_array) check("tag_without_data", write_tag_array, 0);
    end
  endtask

  // Drives the miss in cycle 0 and queues the expected requests/writes.
  task automatic start_miss(input logic [15:0] a);
    int s;
`ifdef CACHE_FILL_CRIT_WORD_EN
    s = int'(a[3:1]);
`else
    s = 0;
`endif
    for (int i = 0; i < 8; i++) begin
      logic [2:0] w;
      w = 3'((s + i) % 8);
      addr_q.push_back({a[15:4], w, 1'b0});
      idx_q.push_back(w);
    end
    cyc = 0; first_req = -1; last_req = -1; first_wr = -1; tag_cyc = -1; fill_wr = 0;
    miss_detected = 1'b1;
    miss_address  = a;
    tick();
    miss_detected = 1'b0;
  endtask

  task automatic run_to_tag(input int budget);
    int t0;
    t0 = n_tag;
    for (int k = 0; k < budget && n_tag == t0; k++) tick();
    check("fill_done", n_tag, t0 + 1);
    check("addr_q_empty", addr_q.size(), 0);
    check("idx_q_empty", idx_q.size(), 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, fsm_busy, 0);
    check({tag, "_men"}, mem_enable, 0);
    check({tag, "_mwr"}, mem_wr, 0);
    check({tag, "_addr"}, memory_address, 0);
    check({tag, "_wda"}, write_data_array, 0);
    check({tag, "_wta"}, write_tag_array, 0);
    check({tag, "_idx"}, word_index, 0);
`ifdef CACHE_FILL_CRIT_WORD_EN
    check({tag, "_crit"}, crit_word_ready, 0);
`endif
  endtask

  initial begin
    int tb4;
    // Reset state, with a miss presented that must be ignored.
    miss_detected = 1'b1;
    miss_address  = 16'h1236;
    @(negedge clk);
    check_idle("reset");
    miss_detected = 1'b0;
    rst = 1'b0;
    tick();
    check_idle("post_reset");

    // Latency 4, miss at 0x1236.
    lat = 4;
    start_miss(16'h1236);
    check("fill_busy_c1", fsm_busy, 1);
    run_to_tag(40);
    check("first_req_cyc", first_req, 1);
    check("last_req_cyc", last_req, 8);
    check("first_wr_cyc", first_wr, 5);
    check("tag_cyc", tag_cyc, 12);
    tick();
    check("busy_drop", fsm_busy, 0);
    repeat (6) tick();

    // Latency 1 with a second miss mid-fill.
    lat = 1;
    start_miss(16'h1230);
    tick();
    miss_detected = 1'b1;
    miss_address  = 16'h4000;
    tick();
    miss_detected = 1'b0;
    run_to_tag(40);
    check("lat1_first_wr", first_wr, 2);
    check("lat1_tag_cyc", tag_cyc, 9);
    repeat (6) tick();

    // Valid while idle must be ignored.
    force_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_valid_wda", write_data_array, 0);
      check("idle_valid_wta", write_tag_array, 0);
      check("idle_valid_busy", fsm_busy, 0);
    end
    force_valid = 1'b0;
    tick();

    // Async reset during the third return.
    lat = 4;
    tb4 = n_tag;
    start_miss(16'h1236);
    for (int k = 0; k < 20 && fill_wr < 3; k++) tick();
    check("third_return_seen", fill_wr, 3);
    #2 rst = 1'b1;
    #1 check_idle("midreset");
    addr_q.delete();
    idx_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (8) tick();
    check("no_tag_after_abort", n_tag, tb4);
    check("no_wr_after_abort", fill_wr, 3);
    check("abort_busy", fsm_busy, 0);

    // Miss at 0x123C (wrapping order when critical-word-first is built in).
    start_miss(16'h123C);
    run_to_tag(40);
    check("c_first_wr", first_wr, 5);
    check("c_tag_cyc", tag_cyc, 12);
    tick();
    check("c_busy_drop", fsm_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
